// File: rtl/outlier_bitmap_collector.sv
// Collects outlier positions from the validation FIFO into a one-bit-per-point
// bitmap RAM, then streams the bitmap out word by word over valid/ready.
module outlier_bitmap_collector #(
    parameter int N          = 16,
    parameter int WORD_W     = 32,
    parameter int MAX_POINTS = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2*N-1:0]    point_cloud_size,
    input  logic              ctrl_done,
    input  logic [N-1:0]      fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [2*N-1:0]    outlier_count,
    output logic              range_error,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);
    localparam int DEPTH = MAX_POINTS / WORD_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(WORD_W);
    localparam int SW    = AW + BW + 1;
    localparam int CW    = 2 * N;
    localparam logic [AW:0] ONE_W = 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COLLECT, S_STREAM} state_t;

    // m_valid/m_data/m_last form a registered source: once m_valid rises, the
    // word and m_last hold until the cycle where m_valid && m_ready.
    state_t              r_state;
    logic [SW-1:0]       r_size;
    logic [AW:0]         r_nw;
    logic [AW-1:0]       r_clr_addr;
    logic [AW:0]         r_s_addr;
    logic                r_p1_valid;
    logic                r_p2_valid;
    logic [AW-1:0]       r_p2_addr;
    logic [BW-1:0]       r_p2_bit;
    logic                r_fwd_valid;
    logic [AW-1:0]       r_fwd_addr;
    logic [WORD_W-1:0]   r_fwd_data;
    logic [WORD_W-1:0]   r_rd_data;
    logic                r_a_valid;
    logic                r_a_last;
    logic                r_m_valid;
    logic                r_m_last;
    logic [WORD_W-1:0]   r_m_data;
    logic [CW-1:0]       r_outlier_count;
    logic                r_range_error;
    logic                r_frame_done;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic                w_oversize;
    logic [SW-1:0]       w_size;
    logic [AW:0]         w_nw;
    logic                w_pop;
    logic                w_p1_in;
    logic [WORD_W-1:0]   w_old;
    logic [WORD_W-1:0]   w_mask;
    logic [WORD_W-1:0]   w_new;
    logic                w_was_set;
    logic                w_out_free;
    logic                w_a_free;
    logic                w_s_issue;
    logic                w_wr_en;
    logic [AW-1:0]       w_wr_addr;
    logic [WORD_W-1:0]   w_wr_data;
    logic                w_rd_en;
    logic [AW-1:0]       w_rd_addr;

    assign w_oversize = point_cloud_size > CW'(MAX_POINTS);
    assign w_size     = w_oversize ? SW'(MAX_POINTS) : point_cloud_size[SW-1:0];
    assign w_nw       = w_size[SW-1:BW] + {{AW{1'b0}}, |w_size[BW-1:0]};

    assign w_pop   = (r_state == S_COLLECT) && !fifo_empty;
    assign w_p1_in = r_p1_valid && (SW'(fifo_dout) < r_size);

    // The write committed on the edge this word was read is not visible in the
    // read data, so take it from the forwarding register instead.
    assign w_old     = (r_fwd_valid && (r_fwd_addr == r_p2_addr)) ? r_fwd_data : r_rd_data;
    assign w_mask    = WORD_W'(1) << r_p2_bit;
    assign w_new     = w_old | w_mask;
    assign w_was_set = |(w_old & w_mask);

    assign w_out_free = !r_m_valid || m_ready;
    assign w_a_free   = !r_a_valid || w_out_free;
    assign w_s_issue  = (r_state == S_STREAM) && w_a_free && (r_s_addr < r_nw);

    assign w_wr_en   = (r_state == S_CLEAR) || r_p2_valid;
    assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_addr : r_p2_addr;
    assign w_wr_data = (r_state == S_CLEAR) ? '0 : w_new;
    assign w_rd_en   = w_p1_in || w_s_issue;
    assign w_rd_addr = w_p1_in ? fifo_dout[BW +: AW] : r_s_addr[AW-1:0];

    always_ff @(posedge clock) begin
        if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
        if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
        r_p2_addr  <= fifo_dout[BW +: AW];
        r_p2_bit   <= fifo_dout[BW-1:0];
        r_fwd_addr <= r_p2_addr;
        r_fwd_data <= w_new;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_size          <= '0;
            r_nw            <= '0;
            r_clr_addr      <= '0;
            r_s_addr        <= '0;
            r_p1_valid      <= 1'b0;
            r_p2_valid      <= 1'b0;
            r_fwd_valid     <= 1'b0;
            r_a_valid       <= 1'b0;
            r_a_last        <= 1'b0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
            r_m_data        <= '0;
            r_outlier_count <= '0;
            r_range_error   <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_p1_valid   <= w_pop;
            r_p2_valid   <= w_p1_in;
            r_fwd_valid  <= r_p2_valid;
            if (r_p1_valid && !w_p1_in) r_range_error <= 1'b1;
            if (r_p2_valid && !w_was_set) r_outlier_count <= r_outlier_count + CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size          <= w_size;
                        r_nw            <= w_nw;
                        r_outlier_count <= '0;
                        r_range_error   <= w_oversize;
                        r_clr_addr      <= '0;
                        if (w_nw == '0) r_frame_done <= 1'b1;
                        else            r_state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if ({1'b0, r_clr_addr} == r_nw - ONE_W) r_state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (ctrl_done && fifo_empty && !r_p1_valid && !r_p2_valid) begin
                        r_state   <= S_STREAM;
                        r_s_addr  <= '0;
                        r_a_valid <= 1'b0;
                        r_m_valid <= 1'b0;
                    end
                end
                S_STREAM: begin
                    // Two-deep pipe: RAM read register, then output register.
                    if (w_s_issue) begin
                        r_s_addr  <= r_s_addr + ONE_W;
                        r_a_valid <= 1'b1;
                        r_a_last  <= (r_s_addr == r_nw - ONE_W);
                    end else if (w_a_free) begin
                        r_a_valid <= 1'b0;
                    end
                    if (w_out_free) begin
                        r_m_valid <= r_a_valid;
                        if (r_a_valid) begin
                            r_m_data <= r_rd_data;
                            r_m_last <= r_a_last;
                        end
                    end
                    if (r_m_valid && m_ready && r_m_last) begin
                        r_m_valid    <= 1'b0;
                        r_m_last     <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fifo_rd_en    = w_pop;
    assign m_data        = r_m_data;
    assign m_valid       = r_m_valid;
    assign m_last        = r_m_last;
    assign outlier_count = r_outlier_count;
    assign range_error   = r_range_error;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = r_frame_done;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_outlier_bitmap_collector.sv
// Directed and randomized frames checked against a bitmap model built from
// the frame's positions; the FIFO is modelled as a queue with 1-cycle read.
module tb_outlier_bitmap_collector;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] point_cloud_size = '0;
    logic        ctrl_done = 1'b0;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic [31:0] outlier_count;
    logic        range_error;
    logic        busy;
    logic        frame_done;
    logic [1:0]  dbg_state;

    outlier_bitmap_collector dut (
        .clock(clock), .reset(reset), .start(start),
        .point_cloud_size(point_cloud_size), .ctrl_done(ctrl_done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .outlier_count(outlier_count), .range_error(range_error), .busy(busy),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    logic [15:0] fifo_q[$];
    logic [15:0] pos_q[$];
    logic [31:0] exp_q[$];
    bit          model_bits [65536];
    int n_assert = 0;
    int n_fail = 0;
    int ready_mode = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int vcnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        logic pop_now;
        if (ready_mode == 1) m_ready = ($urandom_range(0, 1) == 1);
        else m_ready = 1'b1;
        #1;
        pop_now = fifo_rd_en;
        if (frame_done) done_cnt++;
        if (m_valid) vcnt++;
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("word_data", m_data, exp_q.pop_front());
                chk("word_last", m_last, exp_q.size() == 0);
            end
            hs_cnt++;
            if (hs_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        @(posedge clock);
        #1;
        cyc++;
        if (pop_now && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clock);
    endtask

    task automatic push(input logic [15:0] p);
        fifo_q.push_back(p);
        fifo_empty = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_count"}, outlier_count, 0);
        chk({tag, "_range_error"}, range_error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Runs one frame with the positions in pos_q; the model is the set of
    // in-range positions laid out as WORD_W-bit words.
    task automatic run_frame(input int size, input int rmode, input bit early, input bit burst);
        int s, nw, exp_cnt, budget;
        bit exp_rerr;
        logic [31:0] w;
        s = (size > 65536) ? 65536 : size;
        nw = (s + 31) / 32;
        exp_rerr = (size > 65536);
        exp_cnt = 0;
        for (int i = 0; i < s; i++) model_bits[i] = 0;
        foreach (pos_q[i]) begin
            if (int'(pos_q[i]) < s) begin
                if (!model_bits[pos_q[i]]) exp_cnt++;
                model_bits[pos_q[i]] = 1;
            end else begin
                exp_rerr = 1;
            end
        end
        exp_q.delete();
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int b = 0; b < 32; b++)
                if (wi * 32 + b < s && model_bits[wi * 32 + b]) w[b] = 1'b1;
            exp_q.push_back(w);
        end
        hs_cnt = 0; done_cnt = 0; vcnt = 0; prev_stall = 0; ready_mode = rmode;
        start = 1'b1;
        point_cloud_size = size;
        if (early) begin
            foreach (pos_q[i]) push(pos_q[i]);
            ctrl_done = 1'b1;
        end
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (!early) begin
            foreach (pos_q[i]) begin
                if (!burst) repeat ($urandom_range(0, 3)) tick();
                push(pos_q[i]);
            end
            repeat ($urandom_range(0, 4)) tick();
            ctrl_done = 1'b1;
        end
        budget = nw * 8 + pos_q.size() * 8 + 100;
        for (int k = 0; k < budget && done_cnt == 0; k++) tick();
        chk("frame_done_seen", done_cnt, 1);
        ctrl_done = 1'b0;
        tick();
        tick();
        chk("frame_done_once", done_cnt, 1);
        chk("words_left", exp_q.size(), 0);
        chk("handshakes", hs_cnt, nw);
        chk("outlier_count", outlier_count, exp_cnt);
        chk("range_error", range_error, exp_rerr);
        chk("busy_idle", busy, 0);
        chk("m_valid_idle", m_valid, 0);
        chk("fifo_drained", fifo_q.size(), 0);
        if (rmode == 0) chk("consecutive_valid", last_cyc - first_cyc + 1, nw);
    endtask

    initial begin
        @(negedge clock);
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        pos_q = '{16'd5, 16'd37, 16'd99};
        run_frame(100, 0, 0, 0);

        pos_q = '{16'd0, 16'd1, 16'd2, 16'd31, 16'd1, 16'd1};
        run_frame(32, 0, 1, 1);
        run_frame(32, 1, 0, 1);

        pos_q = '{16'd100, 16'd7};
        run_frame(100, 0, 0, 0);

        pos_q = '{16'd65535, 16'd0, 16'd40000, 16'd0};
        run_frame(70000, 0, 0, 1);

        pos_q.delete();
        for (int i = 0; i < 10; i++) pos_q.push_back(16'($urandom_range(0, 127)));
        run_frame(128, 1, 0, 0);
        run_frame(128, 0, 0, 1);

        // Reset in the middle of collection, then a clean frame.
        pos_q = '{16'd5, 16'd50};
        hs_cnt = 0; vcnt = 0; prev_stall = 0;
        start = 1'b1;
        point_cloud_size = 100;
        tick();
        start = 1'b0;
        push(16'd5);
        push(16'd50);
        ctrl_done = 1'b0;
        repeat (6) tick();
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        tick();
        fifo_q.delete();
        fifo_empty = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        reset = 1'b1;
        tick();
        pos_q = '{16'd63};
        run_frame(64, 0, 0, 0);

        // Zero-size frame completes immediately with no stream.
        hs_cnt = 0; vcnt = 0; prev_stall = 0; exp_q.delete();
        start = 1'b1;
        point_cloud_size = 0;
        tick();
        start = 1'b0;
        chk("zero_done_pulse", frame_done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_low", frame_done, 0);
        repeat (10) tick();
        chk("zero_no_valid", vcnt, 0);
        chk("zero_no_handshake", hs_cnt, 0);

        for (int f = 0; f < 5; f++) begin
            int sz, np;
            sz = $urandom_range(1, 300);
            np = $urandom_range(0, 20);
            pos_q.delete();
            for (int i = 0; i < np; i++) pos_q.push_back(16'($urandom_range(0, sz + 20)));
            run_frame(sz, $urandom_range(0, 1), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/outlier_bitmap_collector.md
# outlier_bitmap_collector

Drains the outlier-position FIFO filled by the validation controller and builds a per-point outlier bitmap in on-chip RAM, one bit per point (1 = outlier). Once the controller signals completion and the FIFO is empty, it streams the bitmap out word by word over a valid/ready interface to the point-cloud writeback stage. It sits directly downstream of the controller's outlier FIFO.

## Interface
- N, 16: point-position width; FIFO entry width.
- WORD_W, 32: bitmap word width (power of 2).
- MAX_POINTS, 65536: bitmap capacity in points; depth = MAX_POINTS/WORD_W words.

- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset); one clock, synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame. Ignored unless in IDLE.
- point_cloud_size  in  2N  points in frame; sampled on start.
- ctrl_done  in  1  controller finished validation (level).
- fifo_dout  in  N  outlier position; valid the cycle after fifo_rd_en (read latency 1).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop.
- m_data  out  WORD_W  bitmap word; bit b of word w = point w*WORD_W+b.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  final word of frame, qualified by m_valid.
- outlier_count  out  2N  unique outliers recorded this frame.
- range_error  out  1  sticky; out-of-range position or oversized frame.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the last word handshakes.

## Operation
- States: IDLE, CLEAR, COLLECT, STREAM.
- Frame size: S = min(point_cloud_size, MAX_POINTS). NW = ceil(S/WORD_W).
- If point_cloud_size > MAX_POINTS, set range_error.
- IDLE: on start, latch S, clear outlier_count and range_error. If S = 0, pulse frame_done next cycle and stay in IDLE. Otherwise go to CLEAR.
- CLEAR: write zero to words 0..NW-1, one per cycle, then go to COLLECT. fifo_rd_en stays 0 throughout.
- COLLECT:
  - Assert fifo_rd_en whenever !fifo_empty; at most one pop per cycle.
  - For each popped position p with p < S: set bit p%WORD_W of word p/WORD_W by read-modify-write.
  - Increment outlier_count only if that bit was previously 0, so duplicates count once.
  - If p >= S: drop the entry and set range_error.
  - Back-to-back pops to the same word must all land. The read-modify-write pipeline forwards in-flight write data; no lost bits.
  - Leave COLLECT when ctrl_done=1, fifo_empty=1, no pop is outstanding and the pipeline is drained. Then go to STREAM.
- STREAM:
  - Emit words 0..NW-1 in order, with m_last on word NW-1.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a handshake.
  - Bits at or above S in the last word are 0.
  - After the last handshake, pulse frame_done and go to IDLE.
- outlier_count and range_error hold their values in IDLE until the next start.
- start while busy: ignored.

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, outlier_count=0, range_error=0, busy=0, frame_done=0; state IDLE.
- Reset mid-frame: return to IDLE next cycle with all outputs at reset values. Bitmap RAM contents are don't-care, because the next CLEAR rewrites them.
- Latency, start to COLLECT: 1 + NW cycles.
- Pop-to-RAM-write latency: 2 cycles, via FIFO read cycle then RAM read. Sustained rate is 1 pop per cycle.
- First m_valid comes no more than 2 cycles after entering STREAM.
- With m_ready held high, STREAM outputs one word per cycle, giving NW consecutive valid cycles.
- ctrl_done asserted while the FIFO is non-empty: keep draining; STREAM starts only after the last write commits.
- ctrl_done asserted during CLEAR: takes effect in COLLECT.

## Test plan
- Basic frame: size=100 (NW=4), FIFO positions {5, 37, 99}, then ctrl_done. Expect words 0x00000020, 0x00000020, 0x00000000, 0x00000008. m_last on word 3, outlier_count=3, frame_done once.
- Same-word hazard: back-to-back positions {0,1,2,31}, then repeats {1,1}, size=32. Expect word0=0x80000007, outlier_count=4, range_error=0.
- Range/size: position 100 with size=100 is dropped and sets range_error. Separately, point_cloud_size=70000 clamps S=65536, streams 2048 words and sets range_error.
- Backpressure: size=128 with m_ready toggling at random. Expect m_data stable while stalled, 4 handshakes in order, no duplicated or skipped words. With m_ready tied to 1, 4 consecutive valid cycles.
- Reset mid-COLLECT, then a new frame: after reset all outputs are 0. A second frame (size=64, position {63}) yields 0x00000000 and 0x80000000 with no bits left over from the first frame.
- Zero size: start with size=0. Expect no m_valid and frame_done exactly 1 cycle later.
